// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ transaction FSMs.
// The winner is granted the master and given a one-cycle start pulse. All other
// requesters are held in reset through relinquish. A watchdog takes the bus back
// from an owner that never reports done or fail.
module i2c_bus_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int IDX_W       = 1,
    parameter int WDOG_CYCLES = 27000,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    input  logic [NUM_REQ-1:0] fail,
    input  logic               i2c_bus_busy,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] start,
    output logic [NUM_REQ-1:0] relinquish,
    output logic [IDX_W-1:0]   owner,
    output logic               active,
    output logic               txn_fail,
    output logic               wdog_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t             state_reg;
    logic [IDX_W-1:0]   owner_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [NUM_REQ-1:0] start_reg;
    logic [NUM_REQ-1:0] relinquish_reg;
    logic               active_reg;
    logic               txn_fail_reg;
    logic               wdog_err_reg;

    logic [IDX_W-1:0]   pick_next;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [NUM_REQ-1:0] owner_onehot;
    logic               done_own;
    logic               fail_own;

    // First requesting index strictly after the last owner, wrapping around.
    // The loop runs from the farthest candidate to the nearest so the nearest
    // one overwrites the others and wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] idx;
        sel = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last) + k) % NUM_REQ);
            if (r[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

    // Round-robin choice for the next grant, evaluated against the last owner.
    always_comb begin
        pick_next = rr_pick(req, owner_reg);
    end

    // One-hot decodes of the chosen index and the current owner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_decode
            assign pick_onehot[gi]  = (pick_next == IDX_W'(gi));
            assign owner_onehot[gi] = (owner_reg == IDX_W'(gi));
        end
    endgenerate

    // Only the owner's done/fail matter; everyone else's are masked out.
    assign done_own = |(done & owner_onehot);
    assign fail_own = |(fail & owner_onehot);

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            owner_reg      <= IDX_W'(NUM_REQ - 1);
            cnt_reg        <= '0;
            grant_reg      <= '0;
            start_reg      <= '0;
            relinquish_reg <= '0;
            active_reg     <= 1'b0;
            txn_fail_reg   <= 1'b0;
            wdog_err_reg   <= 1'b0;
        end else begin
            start_reg    <= '0;
            txn_fail_reg <= 1'b0;
            wdog_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        owner_reg      <= pick_next;
                        grant_reg      <= pick_onehot;
                        start_reg      <= pick_onehot;
                        relinquish_reg <= ~pick_onehot;
                        active_reg     <= 1'b1;
                        state_reg      <= GRANT;
                    end
                end
                GRANT: begin
                    cnt_reg   <= '0;
                    state_reg <= BUSY;
                end
                BUSY: begin
                    // The watchdog keeps counting into RELEASE, so always advance.
                    cnt_reg <= cnt_reg + 1'b1;
                    if (fail_own) begin
                        // Fail also covers a simultaneous done.
                        txn_fail_reg   <= 1'b1;
                        grant_reg      <= '0;
                        relinquish_reg <= '1;
                        state_reg      <= RELEASE;
                    end else if (done_own) begin
                        grant_reg      <= '0;
                        relinquish_reg <= '1;
                        state_reg      <= RELEASE;
                    end else if (cnt_reg == WDOG_LAST) begin
                        // Hung owner: abort it along with everyone else.
                        txn_fail_reg   <= 1'b1;
                        wdog_err_reg   <= 1'b1;
                        grant_reg      <= '0;
                        relinquish_reg <= '1;
                        state_reg      <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!i2c_bus_busy) begin
                        relinquish_reg <= '0;
                        active_reg     <= 1'b0;
                        state_reg      <= IDLE;
                    end else if (cnt_reg == CNT_MAX) begin
                        // The master never went idle; give up waiting for it.
                        wdog_err_reg   <= 1'b1;
                        relinquish_reg <= '0;
                        active_reg     <= 1'b0;
                        state_reg      <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign grant      = grant_reg;
    assign start      = start_reg;
    assign relinquish = relinquish_reg;
    assign owner      = owner_reg;
    assign active     = active_reg;
    assign txn_fail   = txn_fail_reg;
    assign wdog_err   = wdog_err_reg;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: 2 requesters, 16-cycle watchdog, 5-bit counter.
module tb_i2c_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] fail;
    logic       i2c_bus_busy;
    logic [1:0] grant;
    logic [1:0] start;
    logic [1:0] relinquish;
    logic [0:0] owner;
    logic       active;
    logic       txn_fail;
    logic       wdog_err;

    int checks;
    int errors;
    int start_pulses;

    i2c_bus_arbiter #(
        .NUM_REQ    (2),
        .IDX_W      (1),
        .WDOG_CYCLES(16),
        .CNT_W      (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .fail        (fail),
        .i2c_bus_busy(i2c_bus_busy),
        .grant       (grant),
        .start       (start),
        .relinquish  (relinquish),
        .owner       (owner),
        .active      (active),
        .txn_fail    (txn_fail),
        .wdog_err    (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the edge into GRANT; owner finishes with done one
    // cycle into BUSY; returns just after the edge back into IDLE.
    task automatic txn(input string tag, input logic [1:0] exp_grant, input logic [0:0] exp_owner);
        chk({tag, " grant"}, 32'(grant), 32'(exp_grant));
        chk({tag, " start"}, 32'(start), 32'(exp_grant));
        chk({tag, " owner"}, 32'(owner), 32'(exp_owner));
        step();
        done = exp_grant;
        step();
        chk({tag, " rel grant"}, 32'(grant), 32'h0);
        chk({tag, " rel txn_fail"}, 32'(txn_fail), 32'h0);
        done = 2'b00;
        step();
        chk({tag, " idle active"}, 32'(active), 32'h0);
        $display("txn %s: grant=%b owner=%0d", tag, exp_grant, exp_owner);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        start_pulses = 0;
        reset        = 1'b1;
        req          = 2'b00;
        done         = 2'b00;
        fail         = 2'b00;
        i2c_bus_busy = 1'b0;
        step();
        step();

        // Reset state
        chk("rst grant", 32'(grant), 32'h0);
        chk("rst start", 32'(start), 32'h0);
        chk("rst relinquish", 32'(relinquish), 32'h0);
        chk("rst owner", 32'(owner), 32'h1);
        chk("rst active", 32'(active), 32'h0);
        chk("rst txn_fail", 32'(txn_fail), 32'h0);
        chk("rst wdog_err", 32'(wdog_err), 32'h0);
        $display("reset: grant=%b owner=%0d active=%b", grant, owner, active);
        reset = 1'b0;
        step();

        // 1. Single request, done 5 cycles after start
        req = 2'b01;
        step();
        chk("t1 grant", 32'(grant), 32'h1);
        chk("t1 start", 32'(start), 32'h1);
        chk("t1 relinq grant", 32'(relinquish), 32'h2);
        chk("t1 owner", 32'(owner), 32'h0);
        chk("t1 active", 32'(active), 32'h1);
        req = 2'b00;
        start_pulses = 1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("t1 grant held", 32'(grant), 32'h1);
            chk("t1 relinq busy", 32'(relinquish), 32'h2);
            if (start !== 2'b00) start_pulses++;
        end
        done = 2'b01;
        step();
        chk("t1 start pulses", 32'(start_pulses), 32'h1);
        chk("t1 grant drop", 32'(grant), 32'h0);
        chk("t1 relinq release", 32'(relinquish), 32'h3);
        chk("t1 txn_fail", 32'(txn_fail), 32'h0);
        chk("t1 active release", 32'(active), 32'h1);
        done = 2'b00;
        step();
        chk("t1 idle active", 32'(active), 32'h0);
        chk("t1 idle relinq", 32'(relinquish), 32'h0);
        $display("t1 single request: complete");

        // 2. Round-robin with both requesting; last owner was 0
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i % 2 == 0) txn("t2 rr", 2'b10, 1'b1);
            else            txn("t2 rr", 2'b01, 1'b0);
        end
        req = 2'b00;
        step();
        chk("t2 stays idle", 32'(grant), 32'h0);

        // 5. Stray done/fail from requester 1 while 0 owns the bus
        req = 2'b01;
        step();
        chk("t5 grant", 32'(grant), 32'h1);
        req = 2'b00;
        step();
        done = 2'b10;
        fail = 2'b10;
        step();
        chk("t5 stray grant", 32'(grant), 32'h1);
        chk("t5 stray txn_fail", 32'(txn_fail), 32'h0);
        chk("t5 stray relinq", 32'(relinquish), 32'h2);
        done = 2'b00;
        fail = 2'b00;
        step();
        chk("t5 grant still", 32'(grant), 32'h1);
        done = 2'b01;
        step();
        chk("t5 release grant", 32'(grant), 32'h0);
        done = 2'b00;
        step();
        $display("t5 stray signals: complete");

        // 4. Fail and done together from owner 1, requester 0 waiting
        req = 2'b10;
        step();
        chk("t4 grant", 32'(grant), 32'h2);
        chk("t4 owner", 32'(owner), 32'h1);
        req = 2'b00;
        step();
        done = 2'b10;
        fail = 2'b10;
        req  = 2'b01;
        step();
        chk("t4 txn_fail", 32'(txn_fail), 32'h1);
        chk("t4 wdog_err", 32'(wdog_err), 32'h0);
        chk("t4 grant drop", 32'(grant), 32'h0);
        done = 2'b00;
        fail = 2'b00;
        i2c_bus_busy = 1'b1;
        step();
        chk("t4 txn_fail pulse", 32'(txn_fail), 32'h0);
        chk("t4 hold release", 32'(active), 32'h1);
        chk("t4 hold relinq", 32'(relinquish), 32'h3);
        i2c_bus_busy = 1'b0;
        step();
        chk("t4 idle", 32'(active), 32'h0);
        step();
        chk("t4 next grant", 32'(grant), 32'h1);
        chk("t4 next owner", 32'(owner), 32'h0);
        req = 2'b00;
        $display("t4 fail path: complete");

        // 3. Watchdog: owner 0 never answers; bus drops after busy falls
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("t3 busy grant", 32'(grant), 32'h1);
            chk("t3 busy txn_fail", 32'(txn_fail), 32'h0);
        end
        i2c_bus_busy = 1'b1;
        step();
        chk("t3 txn_fail", 32'(txn_fail), 32'h1);
        chk("t3 wdog_err", 32'(wdog_err), 32'h1);
        chk("t3 grant drop", 32'(grant), 32'h0);
        chk("t3 relinq", 32'(relinquish), 32'h3);
        step();
        chk("t3 wdog pulse", 32'(wdog_err), 32'h0);
        chk("t3 relinq held", 32'(relinquish), 32'h3);
        i2c_bus_busy = 1'b0;
        step();
        chk("t3 idle", 32'(active), 32'h0);
        $display("t3 watchdog: complete");

        // Watchdog with the master stuck busy: counter saturates in RELEASE
        req = 2'b10;
        step();
        chk("sat grant", 32'(grant), 32'h2);
        req = 2'b00;
        i2c_bus_busy = 1'b1;
        for (int i = 1; i <= 16; i++) step();
        step();
        chk("sat wdog entry", 32'(wdog_err), 32'h1);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("sat held", 32'(active), 32'h1);
            chk("sat no wdog", 32'(wdog_err), 32'h0);
        end
        step();
        chk("sat exit wdog", 32'(wdog_err), 32'h1);
        chk("sat exit txn_fail", 32'(txn_fail), 32'h0);
        chk("sat exit active", 32'(active), 32'h0);
        i2c_bus_busy = 1'b0;
        step();
        chk("sat wdog pulse", 32'(wdog_err), 32'h0);
        $display("saturation exit: complete");

        // 6. Reset mid-BUSY (owner 0), then requester 1 first
        req = 2'b01;
        step();
        chk("t6 grant", 32'(grant), 32'h1);
        req = 2'b00;
        step();
        step();
        #3;
        reset = 1'b1;
        #1;
        chk("t6 async grant", 32'(grant), 32'h0);
        chk("t6 async start", 32'(start), 32'h0);
        chk("t6 async relinq", 32'(relinquish), 32'h0);
        chk("t6 async active", 32'(active), 32'h0);
        chk("t6 async owner", 32'(owner), 32'h1);
        step();
        reset = 1'b0;
        req = 2'b10;
        step();
        txn("t6 after reset", 2'b10, 1'b1);
        req = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
